// File: rtl/sensor_frontend_if.sv
// rtl/sensor_frontend_if.sv - sensor pins and slave conduit signals of sensor_frontend
interface sensor_frontend_if;
   logic [2:0]  sensor_raw;
   logic [31:0] ctrl_word;
   logic [2:0]  sensor_status;
   logic        status_change;

   modport master (
      output sensor_raw,
      output ctrl_word,
      input  sensor_status,
      input  status_change
   );

   modport slave (
      input  sensor_raw,
      input  ctrl_word,
      output sensor_status,
      output status_change
   );
endinterface

// File: rtl/sensor_frontend.sv
// rtl/sensor_frontend.sv - sync, debounce, arm-mask and optional sticky latch for door/window/motion; option macro SENSOR_STICKY_LATCH_EN
module sensor_frontend #(
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 50000
) (
   input  logic             csi_clk,
   input  logic             rsi_reset,
   sensor_frontend_if.slave bus
);
   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [2:0]       sync_chain [SYNC_STAGES];
   logic [2:0]       sync;
   logic [2:0]       deb;
   logic [CNT_W-1:0] cnt [3];
   logic [2:0]       mask;
   logic [2:0]       lat;
   logic [2:0]       lat_next;
   logic             change;

   assign mask = bus.ctrl_word[2:0];
   assign sync = sync_chain[SYNC_STAGES-1];

   // Raw lines are asynchronous: pass each through its own flop chain
   always_ff @(posedge csi_clk) begin
      if (rsi_reset) begin
         for (int k = 0; k < SYNC_STAGES; k++) sync_chain[k] <= '0;
      end else begin
         sync_chain[0] <= bus.sensor_raw;
         for (int k = 1; k < SYNC_STAGES; k++) sync_chain[k] <= sync_chain[k-1];
      end
   end

   // Debounce: a level is accepted only after DEBOUNCE_CYCLES consecutive mismatches
   always_ff @(posedge csi_clk) begin
      if (rsi_reset) begin
         deb <= '0;
         for (int i = 0; i < 3; i++) cnt[i] <= '0;
      end else begin
         for (int i = 0; i < 3; i++) begin
            if (sync[i] == deb[i]) begin
               cnt[i] <= '0;
            end else if (cnt[i] == CNT_LAST) begin
               deb[i] <= sync[i];
               cnt[i] <= '0;
            end else begin
               cnt[i] <= cnt[i] + 1'b1;
            end
         end
      end
   end

`ifdef SENSOR_STICKY_LATCH_EN
   logic clr_q;
   logic clr_edge;
   logic unused_ctrl;

   assign clr_edge    = bus.ctrl_word[4] & ~clr_q;
   assign unused_ctrl = ^bus.ctrl_word[31:5];

   // Clear wins over the sticky OR, so a still-active channel survives a clear
   always_comb begin
      lat_next = deb & mask;
      if (!clr_edge && bus.ctrl_word[3]) lat_next = (lat | deb) & mask;
   end

   // Remember the clear bit so only its 0->1 transition acts
   always_ff @(posedge csi_clk) begin
      if (rsi_reset) clr_q <= 1'b0;
      else           clr_q <= bus.ctrl_word[4];
   end
`else
   logic unused_ctrl;

   assign unused_ctrl = ^bus.ctrl_word[31:3];

   // Without the latch option the status is just the armed debounced level
   always_comb begin
      lat_next = deb & mask;
   end
`endif

   // Status register and its change pulse land on the same edge
   always_ff @(posedge csi_clk) begin
      if (rsi_reset) begin
         lat    <= '0;
         change <= 1'b0;
      end else begin
         lat    <= lat_next;
         change <= (lat_next != lat);
      end
   end

   assign bus.sensor_status = lat;
   assign bus.status_change = change;
endmodule

// File: doc/sensor_frontend.md
# sensor_frontend

Conditions the three raw security-sensor lines (door, window, motion) and drives the 3-bit sensor status input of the Avalon-MM slave that the CPU reads. Each channel is synchronised, debounced, masked by the CPU-written arm bits and optionally held in a sticky alarm latch. Control comes from the slave's 32-bit conduit word, so the block sits directly between the sensor pins and the slave, in both directions.

## Interface
- SYNC_STAGES, 2, flip-flops in each raw-input synchroniser chain (≥2)
- DEBOUNCE_CYCLES, 50000, consecutive mismatching cycles required before a debounced level changes (≥1); 1 ms at 50 MHz
- csi_clk  input  1  sole clock; everything updates on the rising edge
- rsi_reset  input  1  reset, synchronous, active-high
- sensor_raw  input  3  raw sensor lines, asynchronous to csi_clk; bit0 door, bit1 window, bit2 motion
- ctrl_word  input  32  level-held control word from the slave conduit
  - [2:0] arm mask
  - [3] sticky mode
  - [4] latch clear
  - [31:5] ignored
- sensor_status  output  3  conditioned status; connects to the slave sensor input
- status_change  output  1  one-cycle pulse whenever sensor_status changes value

## Operation
- Synchroniser: per-channel SYNC_STAGES flop chain; its last stage is sync[i].
- Debounce, per channel: debounced level deb[i] and a counter cnt[i] of width $clog2(DEBOUNCE_CYCLES)+1.
  - sync==deb: cnt<=0.
  - sync!=deb and cnt==DEBOUNCE_CYCLES-1: deb<=sync and cnt<=0.
  - Otherwise: cnt<=cnt+1.
  - A mismatch shorter than DEBOUNCE_CYCLES returns cnt to 0 and leaves deb unchanged. The counter never wraps.
- Latch register lat[2:0] drives sensor_status directly.
  - Non-sticky (ctrl_word[3]=0): lat<=deb & mask.
  - Sticky (ctrl_word[3]=1): lat<=(lat | deb) & mask.
- Clear edge: a registered copy clr_q of ctrl_word[4] is kept. A clear edge is ctrl_word[4]=1 with clr_q=0.
  - On a clear edge, lat<=deb & mask. A channel still active therefore stays 1; clear takes priority over the sticky OR.
  - A held-high clear bit has no further effect. Software must write 0 and then 1 to clear again.
- Masking: clearing a mask bit zeroes that lat bit on the next edge in both modes. Mask changes have no effect on deb or cnt.
- status_change<=(next lat != lat), registered. It is therefore coincident with the edge on which sensor_status takes its new value.
- Reset values: sync chains, deb, cnt, lat, clr_q and status_change are all 0. sensor_status=0 and status_change=0 from the first edge with rsi_reset=1.
- Reset mid-debounce discards partial counts. A raw input held at 1 through reset reappears SYNC_STAGES+DEBOUNCE_CYCLES cycles after release, with a status_change pulse.

## Timing
- Edge E0 is the first edge that samples a new raw level.
  - sync updates at E0+SYNC_STAGES-1.
  - deb updates at E0+SYNC_STAGES+DEBOUNCE_CYCLES-1.
  - sensor_status and status_change update at E0+SYNC_STAGES+DEBOUNCE_CYCLES.
  - With the defaults (SYNC_STAGES=2, DEBOUNCE_CYCLES=4 in the bench) this is 6 cycles.
- ctrl_word to sensor_status: 1 cycle for mask and mode changes. For a clear, lat changes on the edge that sees the 0→1 transition.
- All channels are independent. Simultaneous changes on several channels produce a single status_change pulse.
- No combinational path from any input to any output.

## Configuration
- SENSOR_STICKY_LATCH_EN defined:
  - Sticky mode and latch clear are implemented as described above.
- SENSOR_STICKY_LATCH_EN undefined:
  - ctrl_word[4:3] are ignored and clr_q is not built.
  - lat<=deb & mask always.
  - Debounce, masking, latency and status_change are unchanged.

## Test plan
All scenarios use SYNC_STAGES=2 and DEBOUNCE_CYCLES=4.
- Reset with sensor_raw=3'b111 and mask 3'b111 → sensor_status=0 during reset; 3'b111 exactly 6 cycles after release; one status_change pulse.
- Mask 3'b001; raw bit0 0→1 at E0 → sensor_status=3'b001 at E0+6. A 3-cycle glitch on bit0 → no change and no status_change.
- Sticky mode with mask 3'b010; bit1 pulses high for 10 cycles → status stays 3'b010 after raw returns to 0. Then ctrl_word[4] 0→1 → status 3'b000 on that edge.
- Sticky mode; issue a clear while bit1 is still debounced high → status remains 3'b010 and no status_change.
- Status 3'b100 in non-sticky mode; mask changes to 3'b011 → status 3'b000 one cycle later, with a pulse. Restoring the mask → 3'b100 one cycle later.
- Build without SENSOR_STICKY_LATCH_EN and with ctrl_word[3]=1; bit0 pulses for 10 cycles → status follows deb and returns to 0 after the debounce delay.
